// File: rtl/str_rle_if.sv
// Stream bundle for the run-length compressor: raw sample sink (sti_*) and
// (value, count) pair source (sto_*). The slave modport is the compressor side.
interface str_rle_if #(
  parameter int DW = 32,
  parameter int CW = 16
);
  logic          sti_tvalid;
  logic          sti_tready;
  logic [DW-1:0] sti_tdata;
  logic          sti_tlast;
  logic          sto_tvalid;
  logic          sto_tready;
  logic [DW-1:0] sto_tdata;
  logic [CW-1:0] sto_tcnt;
  logic          sto_tlast;

  modport master (
    output sti_tvalid, sti_tdata, sti_tlast, sto_tready,
    input  sti_tready, sto_tvalid, sto_tdata, sto_tcnt, sto_tlast
  );

  modport slave (
    input  sti_tvalid, sti_tdata, sti_tlast, sto_tready,
    output sti_tready, sto_tvalid, sto_tdata, sto_tcnt, sto_tlast
  );
endinterface

// File: rtl/str_rle.sv
// Run-length compressor: collapses equal consecutive sample words into
// (value, count) pairs, splitting on mismatch, counter saturation or tlast.
module str_rle #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic     clk,
  input  logic     rst,
  str_rle_if.slave s
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DW-1:0] hval_reg, hval_next;
  logic [CW-1:0] hcnt_reg, hcnt_next;
  logic          hvld_reg, hvld_next;
  logic          flush_pend_reg, flush_pend_next;
  logic          out_vld_reg, out_vld_next;
  logic [DW-1:0] out_data_reg, out_data_next;
  logic [CW-1:0] out_cnt_reg, out_cnt_next;
  logic          out_last_reg, out_last_next;

  logic slot_free;
  logic sti_tready_int;
  logic accept;

  // The output slot can take a new pair if empty or retiring this cycle.
  assign slot_free      = ~out_vld_reg | s.sto_tready;
  assign sti_tready_int = rst & ~flush_pend_reg & slot_free;
  assign accept         = s.sti_tvalid & sti_tready_int;

  assign s.sti_tready = sti_tready_int;
  assign s.sto_tvalid = out_vld_reg;
  assign s.sto_tdata  = out_data_reg;
  assign s.sto_tcnt   = out_cnt_reg;
  assign s.sto_tlast  = out_last_reg;

  always_comb begin
    hval_next       = hval_reg;
    hcnt_next       = hcnt_reg;
    hvld_next       = hvld_reg;
    flush_pend_next = flush_pend_reg;
    out_vld_next    = out_vld_reg;
    out_data_next   = out_data_reg;
    out_cnt_next    = out_cnt_reg;
    out_last_next   = out_last_reg;

    if (out_vld_reg && s.sto_tready) begin
      out_vld_next = 1'b0;
    end

    if (accept) begin
      if (!hvld_reg) begin
        hval_next = s.sti_tdata;
        hcnt_next = CNT_ONE;
        hvld_next = 1'b1;
      end else if ((s.sti_tdata == hval_reg) && (hcnt_reg != CNT_MAX)) begin
        hcnt_next = hcnt_reg + CNT_ONE;
      end else begin
        // Mismatch or saturated counter: close the held run, start a new one.
        out_vld_next  = 1'b1;
        out_data_next = hval_reg;
        out_cnt_next  = hcnt_reg;
        out_last_next = 1'b0;
        hval_next     = s.sti_tdata;
        hcnt_next     = CNT_ONE;
      end
      if (s.sti_tlast) begin
        flush_pend_next = 1'b1;
      end
    end else if (flush_pend_reg && slot_free) begin
      out_vld_next    = 1'b1;
      out_data_next   = hval_reg;
      out_cnt_next    = hcnt_reg;
      out_last_next   = 1'b1;
      hvld_next       = 1'b0;
      flush_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hval_reg       <= '0;
      hcnt_reg       <= '0;
      hvld_reg       <= 1'b0;
      flush_pend_reg <= 1'b0;
      out_vld_reg    <= 1'b0;
      out_data_reg   <= '0;
      out_cnt_reg    <= '0;
      out_last_reg   <= 1'b0;
    end else begin
      hval_reg       <= hval_next;
      hcnt_reg       <= hcnt_next;
      hvld_reg       <= hvld_next;
      flush_pend_reg <= flush_pend_next;
      out_vld_reg    <= out_vld_next;
      out_data_reg   <= out_data_next;
      out_cnt_reg    <= out_cnt_next;
      out_last_reg   <= out_last_next;
    end
  end

endmodule

// File: tb/tb_str_rle.sv
// Scoreboard bench for str_rle: captures are split into expected runs by a
// reference model and compared in order against retired output pairs.
module tb_str_rle;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          l;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  str_rle_if #(.DW(DW), .CW(CW)) bus ();
  str_rle #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst(rst), .s(bus));

  pair_t         exp_q[$];
  logic [DW-1:0] cap_q[$];
  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  int acc_cycle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.sto_tready <= 1'b1;
      1:       bus.sto_tready <= ($urandom_range(0, 3) != 0);
      default: bus.sto_tready <= 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int c, input logic l);
    pair_t p;
    p.d = d;
    p.c = CW'(c);
    p.l = l;
    exp_q.push_back(p);
  endtask

  // Reference: split the capture into maximal equal runs of at most MAXC samples.
  task automatic model_capture();
    int i = 0;
    int j;
    while (i < cap_q.size()) begin
      j = i;
      while (j < cap_q.size() && cap_q[j] == cap_q[i] && (j - i) < MAXC) j++;
      push_exp(cap_q[i], j - i, j == cap_q.size());
      i = j;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    bus.sti_tvalid = 1'b1;
    bus.sti_tdata  = d;
    bus.sti_tlast  = l;
    @(negedge clk);
    while (!bus.sti_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("sti_tready_accept", bus.sti_tready, 1);
    @(posedge clk);
    acc_cycle = cyc;
    #1;
    bus.sti_tvalid = 1'b0;
    bus.sti_tlast  = 1'b0;
  endtask

  task automatic send_capture(input bit with_last, input bit gaps);
    for (int k = 0; k < cap_q.size(); k++) begin
      send_beat(cap_q[k], with_last && (k == cap_q.size() - 1));
      if (gaps && $urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_sto_tvalid", bus.sto_tvalid, 0);
    chk("rst_sto_tdata", bus.sto_tdata, 0);
    chk("rst_sto_tcnt", bus.sto_tcnt, 0);
    chk("rst_sto_tlast", bus.sto_tlast, 0);
    chk("rst_sti_tready", bus.sti_tready, 0);
  endtask

  // Monitor: pops on every retired pair; also checks stall stability.
  initial begin
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    logic [CW-1:0] pc;
    pair_t         e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pc = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("stall_tvalid", bus.sto_tvalid, 1);
          chk("stall_tdata", bus.sto_tdata, pd);
          chk("stall_tcnt", bus.sto_tcnt, pc);
          chk("stall_tlast", bus.sto_tlast, pl);
        end
        if (bus.sto_tvalid && !bus.sto_tready)
          chk("stall_sti_tready", bus.sti_tready, 0);
        if (bus.sto_tvalid && bus.sto_tready) begin
          $display("pair val=%0h cnt=%0d last=%0b", bus.sto_tdata, bus.sto_tcnt, bus.sto_tlast);
          if (exp_q.size() == 0) begin
            chk("unexpected_pair", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pair_val", bus.sto_tdata, e.d);
            chk("pair_cnt", bus.sto_tcnt, e.c);
            chk("pair_last", bus.sto_tlast, e.l);
          end
        end
        pv = bus.sto_tvalid; pr = bus.sto_tready;
        pd = bus.sto_tdata;  pc = bus.sto_tcnt; pl = bus.sto_tlast;
      end
    end
  end

  initial begin
    int t3_first;
    int n;
    logic [DW-1:0] v;
    int sticky;
    bus.sti_tvalid = 1'b0;
    bus.sti_tdata  = '0;
    bus.sti_tlast  = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1: A,A,A,B(last)
    push_exp(32'hA, 3, 1'b0);
    push_exp(32'hB, 1, 1'b1);
    send_beat(32'hA, 1'b0);
    send_beat(32'hA, 1'b0);
    send_beat(32'hA, 1'b0);
    send_beat(32'hB, 1'b1);
    @(negedge clk);
    chk("t1_tready_after_last", bus.sti_tready, 0);
    chk("t1_closed_run_cnt", bus.sto_tcnt, 3);
    @(negedge clk);
    chk("t1_tready_recovered", bus.sti_tready, 1);
    chk("t1_flush_last", bus.sto_tlast, 1);
    drain();

    // T2: counter saturation
    push_exp(32'hC, MAXC, 1'b0);
    push_exp(32'hC, 20 - MAXC, 1'b1);
    for (int k = 0; k < 20; k++) send_beat(32'hC, k == 19);
    drain();

    // T3: alternating values, full throughput
    cap_q.delete();
    for (int k = 0; k < 8; k++) cap_q.push_back((k % 2 == 0) ? 32'hA : 32'hB);
    model_capture();
    send_beat(cap_q[0], 1'b0);
    t3_first = acc_cycle;
    for (int k = 1; k < 8; k++) send_beat(cap_q[k], k == 7);
    chk("t3_no_stall", acc_cycle - t3_first, 7);
    drain();

    // T4: sink stalls 10 cycles after first pair
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    cap_q.delete();
    cap_q.push_back(32'h11); cap_q.push_back(32'h11);
    cap_q.push_back(32'h22); cap_q.push_back(32'h33);
    model_capture();
    fork
      send_capture(1'b1, 1'b0);
      begin
        n = 0;
        @(negedge clk);
        while (!bus.sto_tvalid && n < 100) begin
          n++;
          @(negedge clk);
        end
        chk("t4_first_valid", bus.sto_tvalid, 1);
        repeat (10) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // T5: flush waits behind an unaccepted pair
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    cap_q.delete();
    cap_q.push_back(32'h55); cap_q.push_back(32'h66);
    model_capture();
    send_capture(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_held_tvalid", bus.sto_tvalid, 1);
    chk("t5_held_not_last", bus.sto_tlast, 0);
    rdy_mode = 0;
    drain();

    // T6a: reset mid-run with hcnt=5
    for (int k = 0; k < 5; k++) send_beat(32'hD, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("t6_no_early_pair", bus.sto_tvalid, 0);
    rst = 1'b0;
    #1;
    chk_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp(32'hD, 1, 1'b1);
    send_beat(32'hD, 1'b1);
    drain();

    // T6b: reset while a pair is held
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_beat(32'hE, 1'b0);
    send_beat(32'hD, 1'b0);
    chk("t6_pair_held", bus.sto_tvalid, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    cap_q.delete();
    cap_q.push_back(32'hF);
    model_capture();
    send_capture(1'b1, 1'b0);
    drain();

    // Random captures under random backpressure
    rdy_mode = 1;
    for (int c = 0; c < 40; c++) begin
      cap_q.delete();
      sticky = $urandom_range(50, 97);
      v = DW'($urandom_range(0, 3));
      for (int k = 0; k < $urandom_range(1, 40); k++) begin
        if (k > 0 && $urandom_range(1, 100) > sticky) v = DW'($urandom_range(0, 3));
        cap_q.push_back(v);
      end
      model_capture();
      send_capture(1'b1, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
